scc_mem_dump_streamer: RTL and testbench

- Hardware-side producer of the post-HALT data-memory dump for the SCC core.
- On a start pulse (driven from halt_f), walks a word-aligned region of data memory through a single read port.
- Emits one {address, value} record per word on a valid/ready stream, consumed by the dump writer or bench.
- Folds every emitted word into a running logic checksum so the consumer can cross-check the region without a software model.

---
 rtl/scc_mem_dump_streamer.sv | 158 +++++++++++++++
 tb/tb_scc_mem_dump_streamer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scc_mem_dump_streamer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : scc_mem_dump_streamer
//  Description : Post-HALT data-memory dump producer. Walks a word-aligned
//                region through a single read port, streams one
//                {address, value} record per word on a valid/ready interface
//                and folds every emitted word into a running checksum.
//  Revision    : 1.0 - initial release
// ============================================================================
module scc_mem_dump_streamer #(
    parameter int          ADDR_W    = 16,
    parameter int          CNT_W     = 12,
    parameter int          MEM_LAT   = 1,
    parameter logic [31:0] CSUM_INIT = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [31:0]       dump_addr,
    output logic [31:0]       dump_data,
    output logic              dump_last,
    output logic              busy,
    output logic              done,
    output logic [31:0]       csum
);

    // Read latency counter only needs to reach MEM_LAT-1 (MEM_LAT is 1 or 2).
    localparam logic [1:0] c_lat_last = 2'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_remaining;
    logic [31:0]       r_data;
    logic [1:0]        r_lat_cnt;
    logic [31:0]       r_csum;
    logic              r_done;

    logic              w_last;
    logic              w_lat_done;
    logic [31:0]       w_csum_nxt;

    assign w_last     = (r_remaining == CNT_W'(1));
    assign w_lat_done = (r_lat_cnt == c_lat_last);
    // Checksum fold of the record currently being handed over.
    assign w_csum_nxt = r_csum ^ r_data ^ ((r_data >> 3) & (r_data << 5));

    assign mem_addr  = r_addr;
    assign dump_addr = 32'(r_addr);
    assign dump_data = r_data;
    assign dump_last = (r_state == S_SEND) && w_last;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign csum      = r_csum;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the strobes that are pure functions of state.
    always_comb begin
        w_state_nxt = r_state;
        mem_rd_en   = 1'b0;
        dump_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (word_count == '0) ? S_FIN : S_READ;
                end
            end
            S_READ: begin
                mem_rd_en   = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_lat_done) begin
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                dump_valid = 1'b1;
                if (dump_ready) begin
                    w_state_nxt = w_last ? S_FIN : S_READ;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: region pointer, word counter, read capture, checksum, done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_data      <= '0;
            r_lat_cnt   <= '0;
            r_csum      <= CSUM_INIT;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIN);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= start_addr & ~ADDR_W'(3);
                        r_remaining <= word_count;
                        r_csum      <= CSUM_INIT;
                    end
                end
                S_READ: begin
                    r_lat_cnt <= '0;
                end
                S_WAIT: begin
                    r_lat_cnt <= r_lat_cnt + 2'd1;
                    if (w_lat_done) begin
                        r_data <= mem_rd_data;
                    end
                end
                S_SEND: begin
                    if (dump_ready) begin
                        r_csum      <= w_csum_nxt;
                        r_addr      <= r_addr + ADDR_W'(4);
                        r_remaining <= r_remaining - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scc_mem_dump_streamer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_scc_mem_dump_streamer
//  Description : Scoreboard bench for scc_mem_dump_streamer. Expected records
//                are queued by the stimulus; a negedge monitor pops them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scc_mem_dump_streamer;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [CNT_W-1:0]  word_count;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rd_data;
    logic              dump_valid;
    logic              dump_ready;
    logic [31:0]       dump_addr;
    logic [31:0]       dump_data;
    logic              dump_last;
    logic              busy;
    logic              done;
    logic [31:0]       csum;

    // Second instance with a zero checksum seed.
    logic              start0;
    logic [ADDR_W-1:0] start_addr0;
    logic [CNT_W-1:0]  word_count0;
    logic              mem_rd_en0;
    logic [ADDR_W-1:0] mem_addr0;
    logic [31:0]       mem_rd_data0;
    logic              dump_valid0;
    logic              dump_ready0;
    logic [31:0]       dump_addr0;
    logic [31:0]       dump_data0;
    logic              dump_last0;
    logic              busy0;
    logic              done0;
    logic [31:0]       csum0;

    always #5 clk = ~clk;

    scc_mem_dump_streamer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .MEM_LAT(1),
                            .CSUM_INIT(32'hFFFF_FFFF)) u_dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .word_count(word_count), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_last(dump_last), .busy(busy), .done(done), .csum(csum)
    );

    scc_mem_dump_streamer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .MEM_LAT(1),
                            .CSUM_INIT(32'h0000_0000)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .start_addr(start_addr0),
        .word_count(word_count0), .mem_rd_en(mem_rd_en0), .mem_addr(mem_addr0),
        .mem_rd_data(mem_rd_data0), .dump_valid(dump_valid0),
        .dump_ready(dump_ready0), .dump_addr(dump_addr0), .dump_data(dump_data0),
        .dump_last(dump_last0), .busy(busy0), .done(done0), .csum(csum0)
    );

    // Single-cycle-latency data memory shared by both instances.
    logic [31:0] mem [0:16383];
    always @(posedge clk) begin
        if (mem_rd_en)  mem_rd_data  <= mem[mem_addr[15:2]];
        if (mem_rd_en0) mem_rd_data0 <= mem[mem_addr0[15:2]];
    end

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        l;
    } rec_t;

    rec_t exp_q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   rd_count   = 0;
    int   done_count = 0;
    int   bp_mode    = 0;   // 0: ready high, 1: random, 2: ready low

    // Consumer ready driver.
    initial begin
        dump_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       dump_ready = 1'b1;
                1:       dump_ready = 1'($urandom_range(0, 1));
                default: dump_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks stall stability.
    initial begin
        logic        stall_pend;
        logic [31:0] stall_a;
        logic [31:0] stall_d;
        logic        stall_l;
        rec_t        e;
        stall_pend = 1'b0;
        stall_a    = '0;
        stall_d    = '0;
        stall_l    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_pend = 1'b0;
            end else begin
                if (stall_pend) begin
                    checks++;
                    if (!dump_valid || dump_addr !== stall_a || dump_data !== stall_d
                        || dump_last !== stall_l) begin
                        errors++;
                        $display("FAIL stall_stable: got v=%0b a=%h d=%h l=%0b want v=1 a=%h d=%h l=%0b",
                                 dump_valid, dump_addr, dump_data, dump_last, stall_a, stall_d, stall_l);
                    end
                end
                if (mem_rd_en) begin
                    rd_count++;
                    checks++;
                    if (dump_valid) begin
                        errors++;
                        $display("FAIL read_while_pending: mem_rd_en=1 dump_valid=1, want dump_valid=0");
                    end
                end
                if (done) done_count++;
                if (dump_valid && dump_ready) begin
                    stall_pend = 1'b0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_record: got a=%h d=%h, want none", dump_addr, dump_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (dump_addr !== e.a || dump_data !== e.d || dump_last !== e.l) begin
                            errors++;
                            $display("FAIL record: got a=%h d=%h l=%0b want a=%h d=%h l=%0b",
                                     dump_addr, dump_data, dump_last, e.a, e.d, e.l);
                        end
                    end
                end else if (dump_valid) begin
                    stall_pend = 1'b1;
                    stall_a    = dump_addr;
                    stall_d    = dump_data;
                    stall_l    = dump_last;
                end else begin
                    stall_pend = 1'b0;
                end
            end
        end
    end

    function automatic logic [31:0] fold(input logic [31:0] c, input logic [31:0] w);
        return c ^ w ^ ((w >> 3) & (w << 5));
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_rec(input logic [31:0] a, input logic [31:0] d, input logic l);
        rec_t r;
        r.a = a;
        r.d = d;
        r.l = l;
        exp_q.push_back(r);
    endtask

    task automatic push_six();
        push_rec(32'h0000_D504, 32'hDEAD_BEEF, 1'b0);
        push_rec(32'h0000_D508, 32'h1234_5678, 1'b0);
        push_rec(32'h0000_D50C, 32'h90AB_CDEF, 1'b0);
        push_rec(32'h0000_D510, 32'h0000_0000, 1'b0);
        push_rec(32'h0000_D514, 32'h8765_4321, 1'b0);
        push_rec(32'h0000_D518, 32'h0F0F_0F0F, 1'b1);
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] n);
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = a;
        word_count = n;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_start0(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] n);
        @(posedge clk);
        #1;
        start0      = 1'b1;
        start_addr0 = a;
        word_count0 = n;
        @(posedge clk);
        #1;
        start0 = 1'b0;
    endtask

    task automatic wait_done(input string name, input bit which0, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if ((!which0 && done) || (which0 && done0)) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: done not seen within %0d cycles, want done pulse", name, budget);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int rd0;
        int dn0;
        bit found;
        rst         = 1'b1;
        start       = 1'b0;
        start_addr  = '0;
        word_count  = '0;
        start0      = 1'b0;
        start_addr0 = '0;
        word_count0 = '0;
        dump_ready0 = 1'b1;
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        mem[16'hD504 >> 2] = 32'hDEAD_BEEF;
        mem[16'hD508 >> 2] = 32'h1234_5678;
        mem[16'hD50C >> 2] = 32'h90AB_CDEF;
        mem[16'hD510 >> 2] = 32'h0000_0000;
        mem[16'hD514 >> 2] = 32'h8765_4321;
        mem[16'hD518 >> 2] = 32'h0F0F_0F0F;
        mem[16'h0100 >> 2] = 32'hDEAD_BEEF;
        mem[16'h0104 >> 2] = 32'h0000_0000;
        mem[16'hFFFC >> 2] = 32'hA5A5_A5A5;
        mem[0]             = 32'h1357_9BDF;

        // Reset state
        idle(3);
        check32("reset_valid", 32'(dump_valid), 32'h0);
        check32("reset_busy",  32'(busy),       32'h0);
        check32("reset_done",  32'(done),       32'h0);
        check32("reset_rd_en", 32'(mem_rd_en),  32'h0);
        check32("reset_csum",  csum,            32'hFFFF_FFFF);
        rst = 1'b0;

        // Six-word dump, ready always high
        rd0 = rd_count;
        dn0 = done_count;
        push_six();
        do_start(16'hD504, 12'd6);
        wait_done("six_done", 1'b0, 100);
        idle(4);
        check32("six_csum",   csum, 32'h2968_7109);
        check32("six_reads",  32'(rd_count - rd0), 32'd6);
        check32("six_dones",  32'(done_count - dn0), 32'd1);
        check32("six_queue",  32'(exp_q.size()), 32'd0);

        // Zero seed instance, single word
        do_start0(16'h0100, 12'd1);
        wait_done("seed0_done", 1'b1, 50);
        check32("seed0_csum_deadbeef", csum0, 32'hCF38_2B2F);
        do_start0(16'h0104, 12'd1);
        wait_done("seed0_done_zero", 1'b1, 50);
        check32("seed0_csum_zero", csum0, 32'h0000_0000);

        // Random backpressure
        rd0 = rd_count;
        push_six();
        bp_mode = 1;
        do_start(16'hD504, 12'd6);
        wait_done("bp_done", 1'b0, 600);
        bp_mode = 0;
        idle(4);
        check32("bp_csum",  csum, 32'h2968_7109);
        check32("bp_reads", 32'(rd_count - rd0), 32'd6);
        check32("bp_queue", 32'(exp_q.size()), 32'd0);

        // Zero word count
        rd0 = rd_count;
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = 16'h1234;
        word_count = 12'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check32("zero_done_early", 32'(done), 32'h0);
        @(posedge clk);
        #1;
        check32("zero_done_pulse", 32'(done), 32'h1);
        check32("zero_csum", csum, 32'hFFFF_FFFF);
        idle(4);
        check32("zero_reads", 32'(rd_count - rd0), 32'd0);

        // Address wrap plus ignored start while busy
        rd0 = rd_count;
        push_rec(32'h0000_FFFC, 32'hA5A5_A5A5, 1'b0);
        push_rec(32'h0000_0000, 32'h1357_9BDF, 1'b1);
        do_start(16'hFFFE, 12'd2);
        do_start(16'h0200, 12'd5);
        wait_done("wrap_done", 1'b0, 50);
        idle(25);
        check32("wrap_csum", csum, fold(fold(32'hFFFF_FFFF, 32'hA5A5_A5A5), 32'h1357_9BDF));
        check32("wrap_reads", 32'(rd_count - rd0), 32'd2);
        check32("wrap_queue", 32'(exp_q.size()), 32'd0);

        // Reset during SEND of the third record
        dn0 = done_count;
        push_six();
        do_start(16'hD504, 12'd6);
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (mem_rd_en && mem_addr == 16'hD50C) begin
                found = 1'b1;
                break;
            end
        end
        bp_mode = 2;
        check32("rst_third_read_seen", 32'(found), 32'h1);
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #3;
            if (dump_valid) begin
                found = 1'b1;
                break;
            end
        end
        check32("rst_third_send_seen", 32'(found), 32'h1);
        check32("rst_third_addr", dump_addr, 32'h0000_D50C);
        rst = 1'b1;
        #1;
        check32("rst_mid_valid", 32'(dump_valid), 32'h0);
        check32("rst_mid_busy",  32'(busy), 32'h0);
        check32("rst_mid_data",  dump_data, 32'h0);
        check32("rst_mid_csum",  csum, 32'hFFFF_FFFF);
        exp_q.delete();
        idle(2);
        rst     = 1'b0;
        bp_mode = 0;
        idle(4);
        check32("rst_mid_no_done", 32'(done_count - dn0), 32'd0);

        // Full dump after reset
        rd0 = rd_count;
        push_six();
        do_start(16'hD504, 12'd6);
        wait_done("post_rst_done", 1'b0, 100);
        idle(4);
        check32("post_rst_csum",  csum, 32'h2968_7109);
        check32("post_rst_reads", 32'(rd_count - rd0), 32'd6);
        check32("post_rst_queue", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
